// File: rtl/pipeline_pkg.sv
// Shared helpers for the elastic buffer: pointer width and modulo increment.
// Pointers wrap explicitly so non-power-of-two depths work.
package pipeline_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? unsigned'($clog2(depth)) : 1;
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipeline_buffer_regfile.sv
// Flop array with one write port and one combinational read port.
// Contents clear on reset so the head reads zero out of reset.
module pipeline_buffer_regfile #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4,
    parameter int unsigned AddrWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_elastic_buffer.sv
// Multi-entry elastic buffer: circular queue with registered ready/valid,
// synchronous flush and occupancy count.
module pipeline_elastic_buffer
    import pipeline_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 ready_i,
    output logic [CntWidth-1:0]  count_o
);

    localparam int unsigned PtrWidth = ptr_width(Depth);

    typedef logic [PtrWidth-1:0] ptr_t;

    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                ready_q;
    logic                valid_q;
    logic                push;
    logic                pop;

    assign push = valid_i & ready_q;
    assign pop  = valid_q & ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_t'(ptr_inc(32'(wr_ptr_q), Depth));
            end
            if (pop) begin
                rd_ptr_d = ptr_t'(ptr_inc(32'(rd_ptr_q), Depth));
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntWidth'(1);
                2'b01:   count_d = count_q - CntWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ready/valid are loaded from the next count so both stay pure flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d < CntWidth'(Depth));
            valid_q  <= (count_d != '0);
        end
    end

    pipeline_buffer_regfile #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrWidth (PtrWidth)
    ) u_regfile (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (push & ~flush_i),
        .waddr (wr_ptr_q),
        .wdata (data_i),
        .raddr (rd_ptr_q),
        .rdata (data_o)
    );

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule
